// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - registered fixed-priority arbiter for the shared video/CPU memory port
// Downloader beats eraser beats VTL, except that a VTL starved for MAX_WAIT lost arbitrations wins outright.
module mem_arbiter #(
  parameter int ADDR_W   = 25,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic              F14Mx2,
  input  logic              reset_n,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [7:0]        ldr_wdata,
  output logic              ldr_ack,
  input  logic              ers_req,
  input  logic              ers_we,
  input  logic [ADDR_W-1:0] ers_addr,
  input  logic [7:0]        ers_wdata,
  output logic              ers_ack,
  input  logic              vdc_req,
  input  logic              vdc_we,
  input  logic [ADDR_W-1:0] vdc_addr,
  input  logic [7:0]        vdc_wdata,
  output logic              vdc_ack,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_wr,
  input  logic [7:0]        mem_dout,
  output logic [1:0]        owner,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [2:0] ACC_LAST = 3'(RD_LAT - 1);
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_LDR  = 2'd1;
  localparam logic [1:0] OWN_ERS  = 2'd2;
  localparam logic [1:0] OWN_VDC  = 2'd3;

  state_t            state, state_d;
  logic [2:0]        acc_cnt, acc_cnt_d;
  logic [7:0]        wait_cnt, wait_cnt_d;
  logic              op_we, op_we_d;
  logic [1:0]        owner_d, grant;
  logic              busy_d, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_d, sel_addr;
  logic [7:0]        mem_din_d, sel_wdata, rdata_d;
  logic              sel_we;
  logic [2:0]        ack_d;

  always_comb begin
    grant = OWN_NONE;
    if (vdc_req && wait_cnt == WAIT_MAX) grant = OWN_VDC;
    else if (ldr_req)                    grant = OWN_LDR;
    else if (ers_req)                    grant = OWN_ERS;
    else if (vdc_req)                    grant = OWN_VDC;
  end

  always_comb begin
    sel_addr  = vdc_addr;
    sel_wdata = vdc_wdata;
    sel_we    = vdc_we;
    case (grant)
      OWN_LDR: begin sel_addr = ldr_addr; sel_wdata = ldr_wdata; sel_we = ldr_we; end
      OWN_ERS: begin sel_addr = ers_addr; sel_wdata = ers_wdata; sel_we = ers_we; end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state;
    acc_cnt_d  = acc_cnt;
    wait_cnt_d = wait_cnt;
    op_we_d    = op_we;
    owner_d    = owner;
    busy_d     = busy;
    mem_addr_d = mem_addr;
    mem_din_d  = mem_din;
    mem_wr_d   = 1'b0;
    rdata_d    = rdata;
    ack_d      = 3'b000;
    case (state)
      S_IDLE: begin
        if (grant != OWN_NONE) begin
          state_d    = S_ACCESS;
          acc_cnt_d  = 3'd0;
          owner_d    = grant;
          busy_d     = 1'b1;
          mem_addr_d = sel_addr;
          mem_din_d  = sel_wdata;
          mem_wr_d   = sel_we;
          op_we_d    = sel_we;
          // Starvation count only advances on arbitrations that VTL actually lost.
          if (grant == OWN_VDC)
            wait_cnt_d = 8'd0;
          else if (vdc_req && wait_cnt != WAIT_MAX)
            wait_cnt_d = wait_cnt + 8'd1;
        end
      end
      S_ACCESS: begin
        if (acc_cnt == ACC_LAST) begin
          // Capture read data and raise ack on the same edge so both are valid in DONE.
          state_d = S_DONE;
          if (!op_we) rdata_d = mem_dout;
          ack_d[owner - 2'd1] = 1'b1;
        end else begin
          acc_cnt_d = acc_cnt + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge F14Mx2 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      acc_cnt  <= 3'd0;
      wait_cnt <= 8'd0;
      op_we    <= 1'b0;
      owner    <= OWN_NONE;
      busy     <= 1'b0;
      mem_addr <= '0;
      mem_din  <= 8'd0;
      mem_wr   <= 1'b0;
      rdata    <= 8'd0;
      ldr_ack  <= 1'b0;
      ers_ack  <= 1'b0;
      vdc_ack  <= 1'b0;
    end else begin
      state    <= state_d;
      acc_cnt  <= acc_cnt_d;
      wait_cnt <= wait_cnt_d;
      op_we    <= op_we_d;
      owner    <= owner_d;
      busy     <= busy_d;
      mem_addr <= mem_addr_d;
      mem_din  <= mem_din_d;
      mem_wr   <= mem_wr_d;
      rdata    <= rdata_d;
      ldr_ack  <= ack_d[0];
      ers_ack  <= ack_d[1];
      vdc_ack  <= ack_d[2];
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  localparam int ADDR_W   = 25;
  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 8;

  typedef struct packed {
    logic [1:0] who;
    logic [7:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              ldr_req = 0, ldr_we = 0, ers_req = 0, ers_we = 0, vdc_req = 0, vdc_we = 0;
  logic [ADDR_W-1:0] ldr_addr = '0, ers_addr = '0, vdc_addr = '0;
  logic [7:0]        ldr_wdata = 0, ers_wdata = 0, vdc_wdata = 0;
  logic              ldr_ack, ers_ack, vdc_ack, mem_wr, busy;
  logic [7:0]        rdata, mem_din, mem_dout;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        owner;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [7:0] exp_last = 8'h00;

  logic [7:0] mem [logic [ADDR_W-1:0]];
  logic [7:0] dout_q = 8'h00;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .F14Mx2(clk), .reset_n(reset_n),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
    .ers_req(ers_req), .ers_we(ers_we), .ers_addr(ers_addr), .ers_wdata(ers_wdata), .ers_ack(ers_ack),
    .vdc_req(vdc_req), .vdc_we(vdc_we), .vdc_addr(vdc_addr), .vdc_wdata(vdc_wdata), .vdc_ack(vdc_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .owner(owner), .busy(busy)
  );

  function automatic logic [7:0] pat(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ {7'd0, a[24]} ^ 8'h3C;
  endfunction

  // Memory model: one register stage gives data in the last ACCESS cycle for RD_LAT=2.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] = mem_din;
    dout_q <= mem.exists(mem_addr) ? mem[mem_addr] : pat(mem_addr);
  end
  assign mem_dout = dout_q;

  logic [2:0] mon_acks;
  logic [1:0] mon_who;
  logic       prev_ack = 1'b0;
  exp_t       mon_e;

  always @(negedge clk) begin
    mon_acks = {vdc_ack, ers_ack, ldr_ack};
    if (mon_acks != 3'b000) begin
      checks++;
      if ($countones(mon_acks) != 1 || prev_ack) begin
        errors++;
        $display("FAIL ack_pulse acks=%b prev=%0b required one isolated ack", mon_acks, prev_ack);
      end
      mon_who = vdc_ack ? 2'd3 : (ers_ack ? 2'd2 : 2'd1);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack who=%0d required no ack", mon_who);
      end else begin
        mon_e = sb.pop_front();
        if (mon_who !== mon_e.who || rdata !== mon_e.data) begin
          errors++;
          $display("FAIL sb_ack who=%0d rdata=%h required who=%0d rdata=%h", mon_who, rdata, mon_e.who, mon_e.data);
        end
      end
    end
    prev_ack = (mon_acks != 3'b000);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic [1:0] who, input logic [7:0] d);
    sb.push_back('{who: who, data: d});
    exp_last = d;
  endtask

  task automatic serve(input int n_ldr, input int n_ers, input int n_vdc, input int budget);
    int cyc = 0;
    ldr_req = (n_ldr > 0);
    ers_req = (n_ers > 0);
    vdc_req = (n_vdc > 0);
    while ((n_ldr > 0 || n_ers > 0 || n_vdc > 0) && cyc < budget) begin
      tick();
      cyc++;
      if (ldr_ack) begin n_ldr--; if (n_ldr == 0) ldr_req = 0; end
      if (ers_ack) begin n_ers--; if (n_ers == 0) ers_req = 0; end
      if (vdc_ack) begin n_vdc--; if (n_vdc == 0) vdc_req = 0; end
    end
    checks++;
    if (n_ldr != 0 || n_ers != 0 || n_vdc != 0) begin
      errors++;
      $display("FAIL serve_timeout left ldr=%0d ers=%0d vdc=%0d required 0", n_ldr, n_ers, n_vdc);
    end
    ldr_req = 0; ers_req = 0; vdc_req = 0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n = 0;
    #1;
    checks++;
    if ({ldr_ack, ers_ack, vdc_ack, mem_wr, busy, owner} !== 7'd0 || mem_addr !== '0 || mem_din !== 8'd0 || rdata !== 8'd0) begin
      errors++;
      $display("FAIL reset_values acks=%b wr=%b busy=%b owner=%0d addr=%h din=%h rdata=%h required all 0",
               {ldr_ack, ers_ack, vdc_ack}, mem_wr, busy, owner, mem_addr, mem_din, rdata);
    end
    tick();
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_vdc_read();
    mem[25'h0C123] = 8'h5A;
    vdc_we = 0;
    vdc_addr = 25'h0C123;
    vdc_req = 1;
    push_rd(2'd3, 8'h5A);
    tick();
    checks++;
    if (mem_addr !== 25'h0C123 || owner !== 2'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL vdc_grant addr=%h owner=%0d busy=%b required addr=0c123 owner=3 busy=1", mem_addr, owner, busy);
    end
    tick();
    checks++;
    if (vdc_ack !== 1'b0 || owner !== 2'd3) begin
      errors++;
      $display("FAIL vdc_early_ack ack=%b owner=%0d required ack=0 owner=3", vdc_ack, owner);
    end
    tick();
    checks++;
    if (vdc_ack !== 1'b1) begin
      errors++;
      $display("FAIL vdc_ack_latency ack=%b required 1 at N+3", vdc_ack);
    end
    vdc_req = 0;
    tick();
    checks++;
    if (busy !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL vdc_release busy=%b owner=%0d required busy=0 owner=0", busy, owner);
    end
    tick();
  endtask

  task automatic test_ldr_write();
    int cyc = 0, wr_hits = 0, wr_cyc = -1, ack_cyc = -1;
    ldr_we = 1;
    ldr_addr = 25'h10995;
    ldr_wdata = 8'hC3;
    ldr_req = 1;
    sb.push_back('{who: 2'd1, data: exp_last});
    while (ack_cyc < 0 && cyc < 10) begin
      tick();
      cyc++;
      if (mem_wr) begin
        wr_hits++;
        wr_cyc = cyc;
        checks++;
        if (mem_din !== 8'hC3 || mem_addr !== 25'h10995) begin
          errors++;
          $display("FAIL ldr_wr_data din=%h addr=%h required din=c3 addr=10995", mem_din, mem_addr);
        end
      end
      if (ldr_ack) begin ack_cyc = cyc; ldr_req = 0; end
    end
    ldr_we = 0;
    checks++;
    if (wr_hits != 1 || ack_cyc - wr_cyc != 2) begin
      errors++;
      $display("FAIL ldr_wr_timing wr_cycles=%0d ack_after_wr=%0d required 1 and 2", wr_hits, ack_cyc - wr_cyc);
    end
    tick();
    tick();
    vdc_addr = 25'h10995;
    push_rd(2'd3, 8'hC3);
    serve(0, 0, 1, 20);
  endtask

  task automatic test_all_three();
    ldr_addr = 25'h00111;
    ers_addr = 25'h00222;
    vdc_addr = 25'h00333;
    push_rd(2'd1, pat(25'h00111));
    push_rd(2'd2, pat(25'h00222));
    push_rd(2'd3, pat(25'h00333));
    serve(1, 1, 1, 40);
  endtask

  task automatic test_starvation();
    ldr_addr = 25'h1ABCD;
    vdc_addr = 25'h02468;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < MAX_WAIT; i++) push_rd(2'd1, pat(25'h1ABCD));
      push_rd(2'd3, pat(25'h02468));
    end
    serve(2 * MAX_WAIT, 0, 2, 200);
  endtask

  task automatic test_reset_abort();
    ers_we = 1;
    ers_addr = 25'h01234;
    ers_wdata = 8'h77;
    ers_req = 1;
    tick();
    checks++;
    if (mem_wr !== 1'b1 || owner !== 2'd2) begin
      errors++;
      $display("FAIL ers_grant wr=%b owner=%0d required wr=1 owner=2", mem_wr, owner);
    end
    tick();
    #2;
    reset_n = 0;
    #1;
    checks++;
    if (mem_wr !== 1'b0 || owner !== 2'd0 || busy !== 1'b0 || {ldr_ack, ers_ack, vdc_ack} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset wr=%b owner=%0d busy=%b acks=%b required all 0",
               mem_wr, owner, busy, {ldr_ack, ers_ack, vdc_ack});
    end
    ers_req = 0;
    ers_we = 0;
    exp_last = 8'h00;
    tick();
    reset_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ers_ack !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_ack ack=%b busy=%b required 0 0", ers_ack, busy);
      end
    end
    vdc_addr = 25'h00777;
    push_rd(2'd3, pat(25'h00777));
    serve(0, 0, 1, 20);
  endtask

  task automatic test_drop_after_grant();
    vdc_addr = 25'h00400;
    vdc_req = 1;
    push_rd(2'd3, pat(25'h00400));
    tick();
    vdc_req = 0;
    tick();
    tick();
    checks++;
    if (vdc_ack !== 1'b1) begin
      errors++;
      $display("FAIL drop_ack ack=%b required 1 at N+3", vdc_ack);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || owner !== 2'd0) begin
        errors++;
        $display("FAIL drop_no_retry busy=%b owner=%0d required 0 0", busy, owner);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vdc_read();
    test_ldr_write();
    test_all_three();
    test_starvation();
    test_reset_abort();
    test_drop_after_grant();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sequenced arbiter for the single shared video/CPU memory port (block RAM / SDRAM model) in the Laser 500 core. It replaces the combinational priority mux with a registered request/acknowledge scheme. Three requesters share the port: ROM/PRG downloader, RAM eraser and the VTL chip (CPU + video fetch). Fixed priority applies, plus a starvation guard so VTL fetches are never locked out for long during download or erase.

Parameters:
ADDR_W, 25, memory address width.
RD_LAT, 2, memory read latency in cycles; also the ACCESS-state length; legal range 1..4.
MAX_WAIT, 8, lost-arbitration count after which VTL gets top priority; legal range 1..255.

Ports:
F14Mx2  in  1  memory clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
ldr_req  in  1  downloader request, level, held until ack
ldr_we  in  1  1=write, 0=read
ldr_addr  in  ADDR_W  downloader address
ldr_wdata  in  8  downloader write data
ldr_ack  out  1  one-cycle completion pulse
ers_req / ers_we / ers_addr / ers_wdata / ers_ack  (same widths and meaning, eraser)
vdc_req / vdc_we / vdc_addr / vdc_wdata / vdc_ack  (same widths and meaning, VTL chip)
rdata  out  8  read data, valid in the cycle any ack is high
mem_addr  out  ADDR_W  registered address to memory
mem_din  out  8  registered write data to memory
mem_wr  out  1  registered write strobe
mem_dout  in  8  memory read data
owner  out  2  0=none, 1=ldr, 2=ers, 3=vdc
busy  out  1  high in ACCESS or DONE

Behaviour:
- Reset values: all acks 0, mem_wr 0, mem_addr 0, mem_din 0, rdata 0, owner 0, busy 0, state IDLE, wait counter 0. Reset is asynchronous: asserting reset_n low mid-access forces these values immediately. No ack is issued for the aborted access.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req is high, pick a winner, latch its addr/wdata/we into mem_addr/mem_din/mem_wr, set owner and busy, go to ACCESS. Otherwise stay in IDLE.
- Winner priority:
  - vdc, if vdc_req and wait counter = MAX_WAIT;
  - else ldr > ers > vdc.
- ACCESS: lasts exactly RD_LAT cycles, counted by an internal counter.
  - mem_wr is high only in the first ACCESS cycle (write ops), then drops to 0.
  - mem_addr is held for the whole state.
- DONE: one cycle.
  - rdata <= mem_dout for reads; rdata is unchanged for writes.
  - The owner's ack pulses for exactly this one cycle.
  - Next state is IDLE; owner and busy return to 0 on entering IDLE.
- Latency: with req sampled high in IDLE at cycle N, ack is high at cycle N+RD_LAT+1. The next arbitration happens at N+RD_LAT+2. A requester can therefore be serviced at most once every RD_LAT+2 cycles.
- Wait counter:
  - Increments, saturating at MAX_WAIT, on each IDLE arbitration where vdc_req=1 and vdc loses.
  - Clears to 0 when vdc is granted.
  - Holds in all other cycles.
- Simultaneous requests: exactly one ack per transaction; losing requests stay pending.
- Request dropped before ack: the transaction still completes and ack still pulses; requesters ignore it.
- Request re-asserted or held after ack: treated as a new transaction at the next IDLE.
- Address and data inputs are sampled only in the IDLE grant cycle. Later changes do not affect the running access.
- No request in IDLE: memory outputs keep their last address; mem_wr stays 0.

Test Plan:
- Reset, then single vdc read of 0x0C123 with memory preloaded 0x5A at that address, RD_LAT=2 -> mem_addr=0x0C123 one cycle after sampling; vdc_ack and rdata=0x5A three cycles after req sampled; owner=3 during access.
- ldr write 0x10995<-0xC3 -> mem_wr high exactly one cycle with mem_din=0xC3; ldr_ack two cycles later; readback via vdc returns 0xC3.
- ldr, ers, vdc all request in the same cycle and hold -> grants in order ldr, ers, vdc; each ack a single pulse; no overlap.
- ldr and vdc held continuously, MAX_WAIT=8 -> vdc granted on the 9th arbitration; counter clears; ldr wins the next 8, then vdc again.
- reset_n pulled low during ACCESS of an ers write -> mem_wr, acks, owner, busy go to 0 immediately; no ers_ack after release; the FSM arbitrates normally afterwards.
- vdc_req dropped in the cycle after grant -> vdc_ack still pulses at N+3; no second transaction starts.
